mempool_dma_job_scheduler: RTL and testbench
============================================

# mempool_dma_job_scheduler

Shares a pool of `NumBackends` iDMA backends between a single stream of 1D burst requests from the MemPool DMA frontend. Accepted jobs are buffered in a small FIFO and dispatched to free backends in round-robin order. Each backend's job is tracked until its `trans_complete` pulse. The block sits between the frontend's burst-request output and the backends' request ports, and reports completion count and idleness back to the frontend registers.

## Interface
Parameters:
- `NumBackends`, 4: number of backends; must be at least 1.
- `FifoDepth`, 4: job FIFO entries; must be at least 1.
- `IdWidth`, 8: job id width.
- `burst_req_t`, logic: iDMA 1D burst request struct, passed through untouched.

Ports:
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  burst_req_t  incoming job.
- `req_valid_i`  in  1  job valid.
- `req_ready_o`  out  1  job accepted when high together with `req_valid_i`.
- `job_id_o`  out  IdWidth  id that will be assigned to the job accepted this cycle.
- `be_req_o`  out  NumBackends x burst_req_t  per-backend request.
- `be_valid_o`  out  NumBackends  per-backend valid.
- `be_ready_i`  in  NumBackends  per-backend ready.
- `be_trans_complete_i`  in  NumBackends  single-cycle completion pulse per backend.
- `be_job_id_o`  out  NumBackends x IdWidth  id of the job held by each backend.
- `completed_o`  out  32  count of completed jobs; wraps.
- `idle_o`  out  1  FIFO empty and all backends FREE.
- `stall_cycles_o`  out  32  stall statistics; see Configuration.

## Operation
- **Accept**
  - `req_ready_o` = FIFO not full.
  - On handshake, push {`req_i`, `job_id_o`} and increment the id counter (mod 2^IdWidth).
  - The id counter resets to 0.
- **Per-backend FSM** with states FREE, ISSUE, BUSY.
  - FREE -> ISSUE on dispatch.
  - ISSUE -> BUSY on `be_valid_o & be_ready_i`.
  - BUSY -> FREE on `be_trans_complete_i`.
  - `be_valid_o[k]` = (state == ISSUE).
  - `be_req_o[k]` and `be_job_id_o[k]` are registered at dispatch and stay stable until the backend returns to FREE.
- **Dispatch**
  - At most one job per cycle.
  - Condition: FIFO not empty and at least one backend FREE.
  - Grant goes to the first FREE backend searching upward from the round-robin pointer, wrapping.
  - The FIFO pops and the pointer is set to (grant + 1) mod `NumBackends`.
  - The pointer resets to 0.
- **Completion**
  - Each cycle, `completed_o` += popcount of `be_trans_complete_i` over backends in BUSY.
  - Simultaneous completions from several backends are all counted in the same cycle.
  - A pulse arriving in the same cycle as the ISSUE->BUSY handshake is counted, and the backend goes directly to FREE.
  - A pulse on a FREE backend, or on an ISSUE backend without handshake, is ignored and not counted.
- **Boundaries**
  - Push and pop in the same cycle on a full FIFO is not allowed: `req_ready_o` uses the full flag only, with no pop look-ahead.
  - Push and pop on a non-empty, non-full FIFO keeps occupancy unchanged.
  - The job id counter wraps 2^IdWidth-1 -> 0.
  - A backend that just became FREE, via a completion at edge N, is eligible for dispatch at edge N+1.
- **Reset mid-operation**: all FSMs go to FREE, the FIFO empties, and all counters and the pointer clear. In-flight jobs are dropped; the backends are reset in the same domain.

## Timing
Reset values of outputs:
- `req_ready_o`=1, `job_id_o`=0, `idle_o`=1.
- `be_valid_o`=0, `be_req_o`='0, `be_job_id_o`=0.
- `completed_o`=0, `stall_cycles_o`=0.

Latency and ordering:
- Job accepted at edge N is at the FIFO head in cycle N+1 and dispatched at edge N+1.
- `be_valid_o` rises in cycle N+2, so the minimum request-to-backend latency is 2 cycles. There is no fall-through path.
- `completed_o` and `idle_o` update one cycle after the completion pulse.
- No combinational path from `be_ready_i` or `be_trans_complete_i` to any output.
- `req_ready_o` depends only on registered state.

## Configuration
- `MEMPOOL_DMA_SCHED_STATS_EN` defined: `stall_cycles_o` increments (saturating at 2^32-1) every cycle in which the FIFO is non-empty and no backend is FREE. It clears on reset.
- Not defined: `stall_cycles_o` is tied to 0 and no counter logic is generated.

## Test plan
- **Single job, `NumBackends`=4**: after reset, push one job.
  - `job_id_o`=0 at accept; `be_valid_o`=4'b0001 two cycles later.
  - Hold `be_ready_i[0]` low for 3 cycles: request stays stable.
  - Pulse complete: `completed_o`=1 and `idle_o`=1 next cycle.
- **Round robin**: push 6 jobs with all backends always ready and never completing.
  - Backends 0,1,2,3 receive ids 0,1,2,3.
  - Jobs 4 and 5 stay in the FIFO; `req_ready_o` stays 1 (FifoDepth=4).
  - Complete backend 2: id 4 goes to backend 2.
- **Backpressure**: with all 4 backends BUSY, push until `req_ready_o`=0 after 4 FIFO entries.
  - With stats enabled, `stall_cycles_o` increments every cycle.
- **Simultaneous completion**: pulse complete on backends 0 and 3 in the same cycle -> `completed_o` += 2.
  - A completion in the same cycle as the backend-1 handshake -> counted; backend 1 FREE next cycle.
- **Id wrap**: IdWidth=2; push 5 jobs -> ids 0,1,2,3,0.
- **Reset mid-job**: assert `rst_i` while backends are BUSY and the FIFO holds 2 jobs.
  - All outputs return to reset values immediately (asynchronous).
  - A spurious complete pulse after reset is not counted.

Source files
------------

// File: rtl/mempool_dma_job_scheduler.sv
// Job FIFO plus round-robin dispatcher sharing NumBackends iDMA backends.
// Optional stall statistics are enabled with the MEMPOOL_DMA_SCHED_STATS_EN macro.
module mempool_dma_job_scheduler #(
   parameter int unsigned NumBackends = 4,
   parameter int unsigned FifoDepth   = 4,
   parameter int unsigned IdWidth     = 8,
   parameter type         burst_req_t = logic
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  burst_req_t                          req_i,
   input  logic                                req_valid_i,
   output logic                                req_ready_o,
   output logic [IdWidth-1:0]                  job_id_o,
   output burst_req_t                          be_req_o [NumBackends],
   output logic [NumBackends-1:0]              be_valid_o,
   input  logic [NumBackends-1:0]              be_ready_i,
   input  logic [NumBackends-1:0]              be_trans_complete_i,
   output logic [NumBackends-1:0][IdWidth-1:0] be_job_id_o,
   output logic [31:0]                         completed_o,
   output logic                                idle_o,
   output logic [31:0]                         stall_cycles_o
);

   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam int unsigned BeW  = (NumBackends > 1) ? $clog2(NumBackends) : 1;

   typedef enum logic [1:0] {StFree, StIssue, StBusy} be_state_e;

   burst_req_t           fifo_req [FifoDepth];
   logic [IdWidth-1:0]   fifo_id  [FifoDepth];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      fifo_cnt_q;
   logic                 fifo_full, fifo_empty, push, pop;

   logic [IdWidth-1:0]   id_cnt_q;
   logic [BeW-1:0]       rr_q;
   logic [31:0]          completed_q;

   be_state_e            be_state_q [NumBackends];
   be_state_e            be_state_d [NumBackends];
   burst_req_t           be_req_q   [NumBackends];
   logic [IdWidth-1:0]   be_id_q    [NumBackends];
   logic [NumBackends-1:0] be_free, be_done;

   logic                 grant_valid, dispatch;
   logic [BeW-1:0]       grant_idx;
   logic [31:0]          n_done;

   assign fifo_full   = (fifo_cnt_q == CntW'(FifoDepth));
   assign fifo_empty  = (fifo_cnt_q == '0);
   assign req_ready_o = ~fifo_full;
   assign push        = req_valid_i & ~fifo_full;
   assign pop         = dispatch;
   assign dispatch    = grant_valid & ~fifo_empty;
   assign job_id_o    = id_cnt_q;
   assign completed_o = completed_q;
   assign idle_o      = fifo_empty & (&be_free);

   // First free backend at or above the round-robin pointer, wrapping.
   always_comb begin
      int unsigned sum;
      logic [BeW-1:0] idx;
      sum         = 0;
      idx         = '0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int unsigned i = 0; i < NumBackends; i++) begin
         sum = 32'(rr_q) + i;
         if (sum >= NumBackends) sum = sum - NumBackends;
         idx = BeW'(sum);
         if (!grant_valid && be_free[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end

   always_comb begin
      n_done = '0;
      for (int unsigned k = 0; k < NumBackends; k++) begin
         be_state_d[k] = be_state_q[k];
         be_done[k]    = 1'b0;
         be_free[k]    = (be_state_q[k] == StFree);
         be_valid_o[k] = (be_state_q[k] == StIssue);
         be_job_id_o[k] = be_id_q[k];
         be_req_o[k]   = be_req_q[k];
         unique case (be_state_q[k])
            StFree: begin
               if (dispatch && grant_idx == BeW'(k)) be_state_d[k] = StIssue;
            end
            StIssue: begin
               // A completion coinciding with the handshake retires the job at once.
               if (be_ready_i[k]) begin
                  be_done[k]    = be_trans_complete_i[k];
                  be_state_d[k] = be_trans_complete_i[k] ? StFree : StBusy;
               end
            end
            StBusy: begin
               if (be_trans_complete_i[k]) begin
                  be_done[k]    = 1'b1;
                  be_state_d[k] = StFree;
               end
            end
            default: be_state_d[k] = StFree;
         endcase
         n_done = n_done + 32'(be_done[k]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_req[wr_ptr_q] <= req_i;
         fifo_id[wr_ptr_q]  <= id_cnt_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         id_cnt_q    <= '0;
         rr_q        <= '0;
         completed_q <= '0;
         for (int unsigned k = 0; k < NumBackends; k++) begin
            be_state_q[k] <= StFree;
            be_req_q[k]   <= '0;
            be_id_q[k]    <= '0;
         end
      end else begin
         if (push) begin
            wr_ptr_q <= (32'(wr_ptr_q) == FifoDepth - 1) ? '0 : wr_ptr_q + 1'b1;
            id_cnt_q <= id_cnt_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (32'(rd_ptr_q) == FifoDepth - 1) ? '0 : rd_ptr_q + 1'b1;
            rr_q     <= (32'(grant_idx) == NumBackends - 1) ? '0 : grant_idx + 1'b1;
            be_req_q[grant_idx] <= fifo_req[rd_ptr_q];
            be_id_q[grant_idx]  <= fifo_id[rd_ptr_q];
         end
         fifo_cnt_q  <= fifo_cnt_q + CntW'(push) - CntW'(pop);
         completed_q <= completed_q + n_done;
         for (int unsigned k = 0; k < NumBackends; k++) begin
            be_state_q[k] <= be_state_d[k];
         end
      end
   end

`ifdef MEMPOOL_DMA_SCHED_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (!fifo_empty && !(|be_free) && stall_q != '1) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mempool_dma_job_scheduler.sv
// Self-checking bench: vector table, scoreboard of dispatched jobs, corner-case sequences.
module tb_mempool_dma_job_scheduler;

   typedef logic [15:0] req_t;
   typedef struct packed {req_t req; logic [7:0] id;} job_t;
   typedef struct {
      logic        valid;
      req_t        data;
      logic [3:0]  ready;
      logic [3:0]  cmpl;
      logic        exp_rdy;
      logic [3:0]  exp_valid;
      logic [31:0] exp_comp;
      logic        exp_idle;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   req_t            req = '0;
   logic            req_valid = 1'b0, req_ready;
   logic [7:0]      job_id;
   req_t            be_req [4];
   logic [3:0]      be_valid, be_ready = '0, be_cmpl = '0;
   logic [3:0][7:0] be_job_id;
   logic [31:0]     completed, stall;
   logic            idle;

   req_t            req2 = '0;
   logic            req_valid2 = 1'b0, req_ready2;
   logic [1:0]      job_id2;
   req_t            be_req2 [4];
   logic [3:0]      be_valid2, be_ready2 = 4'hF, be_cmpl2 = '0;
   logic [3:0][1:0] be_job_id2;
   logic [31:0]     completed2, stall2;
   logic            idle2;

   mempool_dma_job_scheduler #(.NumBackends(4), .FifoDepth(4), .IdWidth(8),
                               .burst_req_t(req_t)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_valid_i(req_valid),
      .req_ready_o(req_ready), .job_id_o(job_id), .be_req_o(be_req),
      .be_valid_o(be_valid), .be_ready_i(be_ready), .be_trans_complete_i(be_cmpl),
      .be_job_id_o(be_job_id), .completed_o(completed), .idle_o(idle),
      .stall_cycles_o(stall)
   );

   mempool_dma_job_scheduler #(.NumBackends(4), .FifoDepth(4), .IdWidth(2),
                               .burst_req_t(req_t)) u_dut_w2 (
      .clk_i(clk), .rst_i(rst), .req_i(req2), .req_valid_i(req_valid2),
      .req_ready_o(req_ready2), .job_id_o(job_id2), .be_req_o(be_req2),
      .be_valid_o(be_valid2), .be_ready_i(be_ready2), .be_trans_complete_i(be_cmpl2),
      .be_job_id_o(be_job_id2), .completed_o(completed2), .idle_o(idle2),
      .stall_cycles_o(stall2)
   );

   int   n_checks = 0;
   int   n_fail = 0;
   job_t sbq [$];
   logic [3:0] prev_v = '0;
   vec_t vecs [10];
   logic [1:0] wrap_ids [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock; record accepted jobs and compare each newly issued job in order.
   task automatic tick();
      job_t e;
      if (req_valid && req_ready) sbq.push_back('{req: req, id: job_id});
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (be_valid[k] && !prev_v[k]) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: backend %0d issued id %0h, expected no job",
                        k, be_job_id[k]);
            end else begin
               e = sbq.pop_front();
               check("sb_id", 64'(be_job_id[k]), 64'(e.id));
               check("sb_req", 64'(be_req[k]), 64'(e.req));
            end
         end
      end
      prev_v = be_valid;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_job_id"}, 64'(job_id), 64'd0);
      check({tag, "_idle"}, 64'(idle), 64'd1);
      check({tag, "_be_valid"}, 64'(be_valid), 64'd0);
      check({tag, "_completed"}, 64'(completed), 64'd0);
      check({tag, "_stall"}, 64'(stall), 64'd0);
      check({tag, "_be_job_id"}, 64'(be_job_id), 64'd0);
      for (int k = 0; k < 4; k++) check({tag, "_be_req"}, 64'(be_req[k]), 64'd0);
   endtask

   task automatic apply_reset(input string tag);
      req_valid = 1'b0;
      be_ready  = '0;
      be_cmpl   = '0;
      rst       = 1'b1;
      #3;
      sbq.delete();
      prev_v = '0;
      check_reset(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic push_jobs(input int n, input req_t base);
      for (int i = 0; i < n; i++) begin
         req       = base + req_t'(i);
         req_valid = 1'b1;
         tick();
      end
      req_valid = 1'b0;
   endtask

   initial begin
      int   pushes;
      logic [31:0] s0;

      //          valid data      ready  cmpl   rdy  valid  comp   idle
      vecs[0] = '{1'b1, 16'hA5A5, 4'h0, 4'h0, 1'b1, 4'h0, 32'd0, 1'b0};
      vecs[1] = '{1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h1, 32'd0, 1'b0};
      vecs[2] = '{1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h1, 32'd0, 1'b0};
      vecs[3] = '{1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h1, 32'd0, 1'b0};
      vecs[4] = '{1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h1, 32'd0, 1'b0};
      vecs[5] = '{1'b0, 16'h0000, 4'h1, 4'h0, 1'b1, 4'h0, 32'd0, 1'b0};
      vecs[6] = '{1'b0, 16'h0000, 4'h0, 4'h1, 1'b1, 4'h0, 32'd1, 1'b1};
      vecs[7] = '{1'b0, 16'h0000, 4'h0, 4'h1, 1'b1, 4'h0, 32'd1, 1'b1};
      vecs[8] = '{1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h0, 32'd1, 1'b1};
      vecs[9] = '{1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 4'h0, 32'd1, 1'b1};
      wrap_ids[0] = 2'd0;
      wrap_ids[1] = 2'd1;
      wrap_ids[2] = 2'd2;
      wrap_ids[3] = 2'd3;
      wrap_ids[4] = 2'd0;

      // Single job through backend 0, ready held low while issued.
      apply_reset("rst0");
      check("acc_id", 64'(job_id), 64'd0);
      for (int i = 0; i < 10; i++) begin
         req       = vecs[i].data;
         req_valid = vecs[i].valid;
         be_ready  = vecs[i].ready;
         be_cmpl   = vecs[i].cmpl;
         tick();
         check("vec_ready", 64'(req_ready), 64'(vecs[i].exp_rdy));
         check("vec_be_valid", 64'(be_valid), 64'(vecs[i].exp_valid));
         check("vec_completed", 64'(completed), 64'(vecs[i].exp_comp));
         check("vec_idle", 64'(idle), 64'(vecs[i].exp_idle));
         if (vecs[i].exp_valid[0]) check("vec_be_req0", 64'(be_req[0]), 64'hA5A5);
      end

      // Round robin over four always-ready backends.
      apply_reset("rst1");
      be_ready = 4'hF;
      push_jobs(6, 16'h0100);
      tick();
      tick();
      for (int k = 0; k < 4; k++) check("rr_id", 64'(be_job_id[k]), 64'(k));
      check("rr_ready", 64'(req_ready), 64'd1);
      check("rr_be_valid", 64'(be_valid), 64'd0);
      be_cmpl = 4'b0100;
      tick();
      be_cmpl = '0;
      check("rr_completed", 64'(completed), 64'd1);
      tick();
      check("rr_regrant_valid", 64'(be_valid), 64'b0100);
      check("rr_regrant_id", 64'(be_job_id[2]), 64'd4);
      tick();

      // Backpressure with every backend busy.
      pushes = 0;
      for (int i = 0; i < 10 && req_ready; i++) begin
         req       = 16'h0200 + req_t'(i);
         req_valid = 1'b1;
         tick();
         pushes++;
      end
      check("bp_pushes", 64'(pushes), 64'd3);
      check("bp_ready", 64'(req_ready), 64'd0);
      s0 = stall;
      tick();
      check("bp_id_hold", 64'(job_id), 64'd9);
`ifdef MEMPOOL_DMA_SCHED_STATS_EN
      check("bp_stall1", 64'(stall), 64'(s0 + 32'd1));
      tick();
      check("bp_stall2", 64'(stall), 64'(s0 + 32'd2));
`else
      check("bp_stall1", 64'(stall), 64'd0);
      tick();
      check("bp_stall2", 64'(stall), 64'd0);
`endif
      req_valid = 1'b0;

      // Two completions in one cycle, then refill in round-robin order.
      be_cmpl = 4'b1001;
      tick();
      be_cmpl = '0;
      check("sim_completed", 64'(completed), 64'd3);
      tick();
      check("sim_valid_b3", 64'(be_valid), 64'b1000);
      check("sim_id_b3", 64'(be_job_id[3]), 64'd5);
      tick();
      check("sim_valid_b0", 64'(be_valid), 64'b0001);
      check("sim_id_b0", 64'(be_job_id[0]), 64'd6);

      // Completion on the handshake cycle; stray pulses on ISSUE and FREE ignored.
      apply_reset("rst2");
      push_jobs(2, 16'h0300);
      tick();
      check("hs_valid", 64'(be_valid), 64'b0011);
      be_cmpl = 4'b0001;
      tick();
      check("hs_issue_pulse", 64'(completed), 64'd0);
      check("hs_issue_valid", 64'(be_valid), 64'b0011);
      be_ready = 4'b0010;
      be_cmpl  = 4'b0010;
      tick();
      be_ready = '0;
      be_cmpl  = '0;
      check("hs_completed", 64'(completed), 64'd1);
      check("hs_valid_after", 64'(be_valid), 64'b0001);
      be_cmpl = 4'b0010;
      tick();
      be_cmpl = '0;
      check("hs_free_pulse", 64'(completed), 64'd1);
      check("hs_idle", 64'(idle), 64'd0);

      // Id wrap with a 2-bit id counter.
      for (int i = 0; i < 5; i++) begin
         check("wrap_id", 64'(job_id2), 64'(wrap_ids[i]));
         req2       = 16'h0500 + req_t'(i);
         req_valid2 = 1'b1;
         tick();
      end
      req_valid2 = 1'b0;
      tick();
      tick();
      check("wrap_next", 64'(job_id2), 64'd1);
      for (int k = 0; k < 4; k++) check("wrap_be_id", 64'(be_job_id2[k]), 64'(k));

      // Asynchronous reset with busy backends and two jobs queued.
      apply_reset("rst3");
      be_ready = 4'hF;
      push_jobs(6, 16'h0400);
      tick();
      be_cmpl = 4'b0100;
      tick();
      be_cmpl = '0;
      tick();
      push_jobs(1, 16'h0480);
      tick();
      check("mid_completed_pre", 64'(completed), 64'd1);
      check("mid_idle_pre", 64'(idle), 64'd0);
      rst = 1'b1;
      #3;
      check_reset("midrst");
      sbq.delete();
      prev_v = '0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      be_cmpl = 4'hF;
      tick();
      be_cmpl = '0;
      check("post_rst_completed", 64'(completed), 64'd0);
      check("post_rst_idle", 64'(idle), 64'd1);
      tick();
      check("post_rst_valid", 64'(be_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
